// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target.
// Contents: FSM state enum, ACK/NACK bit levels, byte returned on TX underflow.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRxByte,
        StRxAck,
        StTxByte,
        StTxAck,
        StWaitStop
    } i2c_slv_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [7:0] I2C_UNDERFLOW_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus and FIFO-side signals of the I2C target.
// Pins: scl_i, sda_i (raw levels), sda_o (open-drain drive, 0 = pull low).
// RX FIFO: rx_data, rx_wr, rx_full.  TX FIFO: tx_data, tx_rd, tx_empty.
// Status: busy (addressed), done (STOP ended an addressed transfer).
interface i2c_slave_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic [7:0] rx_data;
    logic       rx_wr;
    logic       rx_full;
    logic [7:0] tx_data;
    logic       tx_rd;
    logic       tx_empty;
    logic       busy;
    logic       done;

    modport slave (
        input  scl_i, sda_i, rx_full, tx_data, tx_empty,
        output sda_o, rx_data, rx_wr, tx_rd, busy, done
    );

    modport master (
        output scl_i, sda_i, rx_full, tx_data, tx_empty,
        input  sda_o, rx_data, rx_wr, tx_rd, busy, done
    );
endinterface

// File: rtl/i2c_slave_line_sync.sv
// SCL/SDA synchronizers plus edge, START and STOP detection.
// Ports: clk, rst (async, active high), scl_pin/sda_pin (raw levels),
//        sda (synchronized level), scl_rise, scl_fall, start, stop (one-clk events).
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl;

    // Reset to the idle-bus level so leaving reset creates no spurious edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
            scl_prev <= scl;
            sda_prev <= sda;
        end
    end

    assign scl      = scl_sync[SYNC_STAGES-1];
    assign sda      = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;
    // SDA may only change with SCL held high across both samples.
    assign start    = scl & scl_prev & sda_prev & ~sda;
    assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_slave.sv
// Byte-oriented I2C target on one 7-bit address.
// Ports: clk, rst (async, active high), bus (i2c_slave_if.slave: pins, FIFO strobes, status).
// Writes go to the RX FIFO via rx_wr; reads are served from the TX FIFO via tx_rd.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    i2c_slave_if.slave bus
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk     (clk),
        .rst     (rst),
        .scl_pin (bus.scl_i),
        .sda_pin (bus.sda_i),
        .sda     (sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    i2c_slv_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, shift_in;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;  // ACK slot: second half reached / master ACK seen
    logic       sda_o_q, sda_o_d;
    logic       rx_wr_q, rx_wr_d;
    logic       tx_rd_q, tx_rd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load_tx, send_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            rx_data_q <= 8'h00;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            sda_o_q   <= 1'b1;
            rx_wr_q   <= 1'b0;
            tx_rd_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            sda_o_q   <= sda_o_d;
            rx_wr_q   <= rx_wr_d;
            tx_rd_q   <= tx_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_o_d    = sda_o_q;
        rx_wr_d    = 1'b0;
        tx_rd_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_tx    = 1'b0;
        send_first = 1'b0;
        shift_in   = {shift_q[6:0], sda};

        // The FIFO presents the byte in the cycle its read strobe is high.
        if (tx_rd_q) begin
            shift_d = bus.tx_data;
        end

        if (stop) begin
            state_d = StIdle;
            sda_o_d = I2C_NACK;
            done_d  = busy_q;
            busy_d  = 1'b0;
            phase_d = 1'b0;
        end else if (start) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd7;
            sda_o_d   = I2C_NACK;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 3'd0) begin
                            if (shift_in[7:1] == SLV_ADDR) begin
                                state_d = StAddrAck;
                                busy_d  = 1'b1;
                                rw_d    = shift_in[0];
                            end else begin
                                state_d = StWaitStop;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_o_d = I2C_ACK;
                            phase_d = 1'b1;
                            load_tx = rw_q;
                        end else begin
                            phase_d = 1'b0;
                            if (rw_q) begin
                                send_first = 1'b1;
                            end else begin
                                state_d   = StRxByte;
                                sda_o_d   = I2C_NACK;
                                bit_cnt_d = 3'd7;
                            end
                        end
                    end
                end
                StRxByte: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 3'd0) begin
                            if (!bus.rx_full) begin
                                rx_wr_d   = 1'b1;
                                rx_data_d = shift_in;
                                state_d   = StRxAck;
                                phase_d   = 1'b0;
                            end else begin
                                // SDA already released: the master reads a NACK.
                                state_d = StWaitStop;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                StRxAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_o_d = I2C_ACK;
                            phase_d = 1'b1;
                        end else begin
                            sda_o_d   = I2C_NACK;
                            phase_d   = 1'b0;
                            state_d   = StRxByte;
                            bit_cnt_d = 3'd7;
                        end
                    end
                end
                StTxByte: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_o_d = I2C_NACK;
                            state_d = StTxAck;
                            phase_d = 1'b0;
                        end else begin
                            sda_o_d   = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b1};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                StTxAck: begin
                    if (!phase_q && scl_rise) begin
                        if (sda == I2C_ACK) begin
                            phase_d = 1'b1;
                            load_tx = 1'b1;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end else if (phase_q && scl_fall) begin
                        phase_d    = 1'b0;
                        send_first = 1'b1;
                    end
                end
                StIdle, StWaitStop: begin
                    sda_o_d = I2C_NACK;
                end
                default: begin
                    state_d = StIdle;
                    sda_o_d = I2C_NACK;
                end
            endcase
        end

        if (load_tx) begin
            if (bus.tx_empty) begin
                shift_d = I2C_UNDERFLOW_BYTE;
            end else begin
                tx_rd_d = 1'b1;
            end
        end

        // First data bit goes out on the fall that ends the preceding ACK slot.
        if (send_first) begin
            state_d   = StTxByte;
            sda_o_d   = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b1};
            bit_cnt_d = 3'd7;
        end
    end

    assign bus.sda_o   = sda_o_q;
    assign bus.rx_data = rx_data_q;
    assign bus.rx_wr   = rx_wr_q;
    assign bus.tx_rd   = tx_rd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bus-master model drives SCL/SDA, a FIFO model serves
// TX bytes, a reference model queues the expected ACK bits, read bytes, RX writes and done
// pulses, and a monitor process compares them as the DUT or the master model produces them.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam logic [6:0] SLV  = 7'h50;
    localparam int         HALF = 8;  // clks per SCL phase

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_slave_if bus ();

    i2c_slave #(
        .SLV_ADDR   (SLV),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Open-drain wired-AND of master and target.
    logic sda_m = 1'b1;
    assign bus.sda_i = sda_m & bus.sda_o;

    logic [7:0] tx_q[$];
    logic [7:0] model_tx[$];
    logic       tx_empty_r = 1'b1;
    logic [7:0] tx_data_r  = 8'h00;
    assign bus.tx_empty = tx_empty_r;
    assign bus.tx_data  = tx_data_r;

    logic       exp_ack[$];
    logic       obs_ack[$];
    logic [7:0] exp_rd[$];
    logic [7:0] obs_rd[$];
    logic [7:0] exp_rx[$];
    int         exp_done    = 0;
    int         tx_rd_cnt   = 0;
    int         sda_low_cnt = 0;
    int         checks      = 0;
    int         failures    = 0;
    logic [7:0] payload[0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        logic rx_wr_prev = 1'b0;
        logic tx_rd_prev = 1'b0;
        logic pop_pending = 1'b0;
        logic has_exp;
        forever begin
            @(negedge clk);
            if (bus.sda_o === 1'b0) sda_low_cnt++;
            if (bus.rx_wr) begin
                has_exp = (exp_rx.size() != 0);
                chk("rx_wr expected", has_exp, 1'b1);
                if (has_exp) chk("rx_data", bus.rx_data, exp_rx.pop_front());
                if (rx_wr_prev) chk("rx_wr one clk wide", 1'b0, rx_wr_prev);
            end
            if (bus.done) begin
                chk("done expected", exp_done > 0, 1'b1);
                if (exp_done > 0) exp_done--;
            end
            if (obs_ack.size() != 0) begin
                has_exp = (exp_ack.size() != 0);
                chk("ack expectation present", has_exp, 1'b1);
                if (has_exp) chk("ack bit", obs_ack.pop_front(), exp_ack.pop_front());
                else void'(obs_ack.pop_front());
            end
            if (obs_rd.size() != 0) begin
                has_exp = (exp_rd.size() != 0);
                chk("read expectation present", has_exp, 1'b1);
                if (has_exp) chk("read byte", obs_rd.pop_front(), exp_rd.pop_front());
                else void'(obs_rd.pop_front());
            end
            if (pop_pending) begin
                if (tx_q.size() != 0) void'(tx_q.pop_front());
                pop_pending = 1'b0;
            end
            if (bus.tx_rd) begin
                chk("tx_rd only with data", tx_q.size() != 0, 1'b1);
                if (tx_rd_prev) chk("tx_rd one clk wide", 1'b0, tx_rd_prev);
                tx_rd_cnt++;
                pop_pending = 1'b1;
            end
            rx_wr_prev = bus.rx_wr;
            tx_rd_prev = bus.tx_rd;
            tx_empty_r = (tx_q.size() == 0);
            tx_data_r  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    // Bus-master model.
    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; bus.scl_i = 1'b1; clocks(HALF);
        sda_m = 1'b0; clocks(HALF);
        bus.scl_i = 1'b0;
    endtask

    task automatic bus_rstart();
        clocks(2); sda_m = 1'b1; clocks(HALF - 2);
        bus.scl_i = 1'b1; clocks(HALF);
        sda_m = 1'b0; clocks(HALF);
        bus.scl_i = 1'b0;
    endtask

    task automatic bus_stop();
        clocks(2); sda_m = 1'b0; clocks(HALF - 2);
        bus.scl_i = 1'b1; clocks(HALF);
        sda_m = 1'b1; clocks(HALF);
    endtask

    task automatic put_bit(input logic b);
        clocks(2); sda_m = b; clocks(HALF - 2);
        bus.scl_i = 1'b1; clocks(HALF);
        bus.scl_i = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        clocks(2); sda_m = 1'b1; clocks(HALF - 2);
        bus.scl_i = 1'b1; clocks(HALF / 2);
        b = bus.sda_i;
        clocks(HALF / 2);
        bus.scl_i = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        obs_ack.push_back(a);
    endtask

    task automatic read_byte(input logic ack);
        logic [7:0] v;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        obs_rd.push_back(v);
        put_bit(ack);
    endtask

    // Write transfer with expectations from the protocol rules.
    task automatic do_write(input logic [7:0] ab, input int n, input bit full,
                            input bit with_stop, input bit rep);
        bit matched;
        bit alive;
        int low0;
        matched = (ab[7:1] == SLV);
        low0 = sda_low_cnt;
        bus.rx_full = full;
        if (rep) bus_rstart(); else bus_start();
        exp_ack.push_back(matched ? I2C_ACK : I2C_NACK);
        write_byte(ab);
        chk("busy after address", bus.busy, matched);
        alive = matched;
        for (int i = 0; i < n; i++) begin
            if (alive && !full) begin
                exp_ack.push_back(I2C_ACK);
                exp_rx.push_back(payload[i]);
            end else begin
                exp_ack.push_back(I2C_NACK);
                alive = 1'b0;
            end
            write_byte(payload[i]);
        end
        if (!matched) chk("sda_o low cycles on foreign address", sda_low_cnt - low0, 0);
        if (with_stop) begin
            if (matched) exp_done++;
            bus_stop();
            clocks(4);
            chk("busy after stop", bus.busy, 1'b0);
        end
        bus.rx_full = 1'b0;
    endtask

    // Read transfer: master ACKs every byte but the last.
    task automatic do_read(input int n, input bit rep);
        int rd0;
        int exp_cnt;
        rd0 = tx_rd_cnt;
        exp_cnt = 0;
        if (rep) bus_rstart(); else bus_start();
        exp_ack.push_back(I2C_ACK);
        write_byte({SLV, 1'b1});
        chk("busy after read address", bus.busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (model_tx.size() != 0) begin
                exp_rd.push_back(model_tx.pop_front());
                exp_cnt++;
            end else begin
                exp_rd.push_back(8'hFF);
            end
            read_byte((i == n - 1) ? I2C_NACK : I2C_ACK);
        end
        exp_done++;
        bus_stop();
        clocks(4);
        chk("tx_rd pulse count", tx_rd_cnt - rd0, exp_cnt);
        chk("busy after read stop", bus.busy, 1'b0);
    endtask

    task automatic fill_tx(input logic [7:0] b);
        tx_q.push_back(b);
        model_tx.push_back(b);
    endtask

    initial begin
        logic [6:0] a7;
        int kind;
        int n;
        int fill;
        bus.scl_i = 1'b1;
        bus.rx_full = 1'b0;
        clocks(3);
        chk("reset sda_o", bus.sda_o, 1'b1);
        chk("reset rx_wr", bus.rx_wr, 1'b0);
        chk("reset tx_rd", bus.tx_rd, 1'b0);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset rx_data", bus.rx_data, 8'h00);
        rst = 1'b0;
        clocks(4);

        payload[0] = 8'h3C; payload[1] = 8'hC3;
        do_write(8'hA0, 2, 1'b0, 1'b1, 1'b0);

        payload[0] = 8'h69;
        do_write(8'hA2, 1, 1'b0, 1'b1, 1'b0);

        fill_tx(8'h5A); fill_tx(8'h96);
        do_read(2, 1'b0);

        payload[0] = 8'h77; payload[1] = 8'h88;
        do_write(8'hA0, 2, 1'b1, 1'b1, 1'b0);

        payload[0] = 8'h11;
        do_write(8'hA0, 1, 1'b0, 1'b0, 1'b0);
        do_read(1, 1'b1);

        // Reset while the target drives the data-byte ACK.
        bus_start();
        exp_ack.push_back(I2C_ACK);
        write_byte(8'hA0);
        exp_rx.push_back(8'h5D);
        for (int i = 7; i >= 0; i--) put_bit(n_bit(8'h5D, i));
        clocks(2); sda_m = 1'b1; clocks(HALF - 2);
        chk("ack driven before reset", bus.sda_o, 1'b0);
        rst = 1'b1;
        #1;
        chk("sda_o released by reset", bus.sda_o, 1'b1);
        chk("busy cleared by reset", bus.busy, 1'b0);
        clocks(2);
        rst = 1'b0;
        bus.scl_i = 1'b1; clocks(HALF);
        bus.scl_i = 1'b0;
        bus_stop();
        clocks(4);
        payload[0] = 8'h22;
        do_write(8'hA0, 1, 1'b0, 1'b1, 1'b0);

        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(9);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) payload[i] = 8'($urandom);
            if (kind < 6) begin
                do_write({SLV, 1'b0}, n, ($urandom_range(6) == 0), 1'b1, 1'b0);
            end else if (kind == 6) begin
                a7 = 7'($urandom);
                if (a7 == SLV) a7 = 7'h51;
                do_write({a7, 1'b0}, n, 1'b0, 1'b1, 1'b0);
            end else begin
                fill = $urandom_range(0, n);
                for (int i = 0; i < fill; i++) fill_tx(8'($urandom));
                do_read(n, 1'b0);
            end
        end

        clocks(10);
        chk("unconsumed rx expectations", exp_rx.size(), 0);
        chk("unconsumed ack expectations", exp_ack.size(), 0);
        chk("unconsumed read expectations", exp_rd.size(), 0);
        chk("missing done pulses", exp_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic n_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Byte-oriented I2C target (slave) on one 7-bit address. Oversamples SCL/SDA on the system clock, detects START/repeated START/STOP, and ACKs its address. Write transfers go into an RX FIFO, and read transfers are served from a TX FIFO. It is the far-end counterpart of the team's I2C master and uses the same FIFO-side strobe style.

## Interface
- `SLV_ADDR`, default 7'h50: address this target answers to.
- `SYNC_STAGES`, default 2: synchronizer depth on `scl_i` and `sda_i`. Must be at least 2.
- `clk` input 1: system clock. Must be at least 8x the SCL frequency.
- `rst` input 1: asynchronous, active-high reset.
- `scl_i` input 1: raw SCL pin level.
- `sda_i` input 1: raw SDA pin level.
- `sda_o` output 1: SDA drive. 0 pulls the line low. 1 releases it (open-drain).
- `rx_data` output 8: received byte. Valid while `rx_wr` is high.
- `rx_wr` output 1: one-clk write strobe to the RX FIFO.
- `rx_full` input 1: RX FIFO full.
- `tx_data` input 8: byte to transmit. Sampled in the cycle `tx_rd` is high.
- `tx_rd` output 1: one-clk read strobe to the TX FIFO.
- `tx_empty` input 1: TX FIFO empty.
- `busy` output 1: high from an address match until STOP or the next START.
- `done` output 1: one-clk pulse on a STOP that ends a transfer addressed to this target.

## Operation
- Sync stages plus one registered copy give per-clk events:
  - `scl_rise`, `scl_fall`.
  - `start`: SDA falls while SCL is high.
  - `stop`: SDA rises while SCL is high.
- SDA data is sampled on `scl_rise`. `sda_o` changes only in the clk after `scl_fall`.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- `start` in any state:
  - Go to ADDR, bit counter = 7, `sda_o` = 1.
  - If the target was addressed, `busy` drops in the same clk.
- `stop` in any state:
  - Go to IDLE, `sda_o` = 1.
  - Pulse `done` if `busy` was high.
- ADDR:
  - Shift 8 bits, MSB first: 7 address bits, then R/W.
  - After the 8th `scl_rise`, a match with `SLV_ADDR` goes to ADDR_ACK and sets `busy`.
  - A mismatch goes to WAIT_STOP, with `sda_o` released.
- ADDR_ACK:
  - Drive `sda_o` = 0 for one SCL period.
  - If R/W = 1, pulse `tx_rd` in the clk the ACK is driven (skipped if `tx_empty`) and load the shifter.
  - On the ACK's `scl_fall`, go to TX_BYTE if R/W = 1, otherwise RX_BYTE.
- RX_BYTE:
  - Shift 8 bits.
  - After the 8th `scl_rise`:
    - If `rx_full` = 0: pulse `rx_wr` with the byte and ACK (`sda_o` = 0) in RX_ACK.
    - If `rx_full` = 1: drop the byte, NACK (`sda_o` = 1), then go to WAIT_STOP.
  - RX_ACK goes back to RX_BYTE on `scl_fall`.
- TX_BYTE:
  - Present `shift[7]` on `sda_o` after each `scl_fall`, MSB first, 8 bits.
  - Then release SDA and go to TX_ACK.
- TX_ACK:
  - Sample the master's bit on `scl_rise`.
  - ACK (0): pulse `tx_rd` (skipped if `tx_empty`) and load the next byte. Go to TX_BYTE on `scl_fall`.
  - NACK (1): go to WAIT_STOP.
- TX underflow: if `tx_empty` at a load point, load 8'hFF.
- WAIT_STOP: `sda_o` = 1. Leave only on `start` or `stop`.

## Timing
- Reset values:
  - State IDLE.
  - `sda_o` = 1, `rx_wr` = 0, `tx_rd` = 0, `busy` = 0, `done` = 0.
  - `rx_data` = 8'h00.
  - Bit counter = 0.
- Event latency:
  - Pin edge to event: `SYNC_STAGES` + 1 clk.
  - `scl_fall` to new `sda_o`: 1 clk, which gives hold time on the bus.
- Strobes:
  - `rx_wr` goes high 1 clk after the 8th `scl_rise` event, for exactly 1 clk.
  - `tx_rd` is exactly 1 clk wide, at most once per byte.
- `start` and `stop` take priority over any `scl_rise`/`scl_fall` in the same clk.
- A `start` during an ACK drive releases SDA in the next clk.
- Reset asserted mid-byte:
  - `sda_o` releases immediately (asynchronous) and the partial byte is discarded.
  - After reset the target ignores the bus until the next `start`.

## Structure
- Package `i2c_pkg`:
  - State enum `i2c_slv_state_e`.
  - `I2C_ACK` = 1'b0, `I2C_NACK` = 1'b1.
  - `I2C_UNDERFLOW_BYTE` = 8'hFF.
- Sub-module `i2c_line_sync`: synchronizers plus the edge/START/STOP detector. It is reusable by a future master rewrite.
- The top level holds the FSM, shifter and bit counter.

## Test plan
- Write 0xA0 (address 0x50, W), then data 0x3C, 0xC3, then STOP:
  - `sda_o` = 0 in all 3 ACK slots.
  - `rx_wr` pulses twice, with `rx_data` 0x3C then 0xC3.
  - `done` pulses once.
- Address 0x51 (mismatch) W:
  - `sda_o` stays 1 throughout, no strobes, `busy` = 0.
- Read 0xA1 with TX FIFO holding 0x5A, 0x96, master ACKs the first byte and NACKs the second:
  - SDA bits read 0x5A then 0x96.
  - `tx_rd` pulses twice, then WAIT_STOP.
- Write with `rx_full` = 1 from the first data byte:
  - Address ACKed, data NACKed, no `rx_wr`.
  - Next byte ignored until STOP.
- Write 0xA0 then data 0x11, then a repeated START with 0xA1 and read from an empty TX FIFO:
  - `rx_wr` with 0x11.
  - Read byte is 0xFF and `tx_rd` is never pulsed.
- `rst` asserted while driving an ACK:
  - `sda_o` = 1 in the same clk.
  - Next transfer 0xA0 / 0x22 completes normally.
